// File: rtl/natural_log_arbiter.sv
// natural_log_arbiter: round-robin sharing of one natural_log pipeline among N_REQ requesters.
// Define NATURAL_LOG_ARBITER_CACHE_EN to answer repeated operands from a per-requester result cache.
module natural_log_arbiter #(
    parameter int N_REQ       = 4,
    parameter int LOG_LATENCY = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*24-1:0] in_8_shifted,
    output logic [N_REQ-1:0]    grant,
    output logic [N_REQ-1:0]    busy,
    output logic [N_REQ-1:0]    done,
    output logic [N_REQ*12-1:0] out_8_shifted
);
    localparam int IW = $clog2(N_REQ);
    logic [N_REQ-1:0]    grant_d, grant_q, busy_d, busy_q, done_d, done_q;
    logic [N_REQ-1:0]    elig, hit, cand, sel_oh, fin_oh;
    logic [N_REQ*12-1:0] out_d, out_q;
    logic [IW-1:0]       ptr_d, ptr_q, sel;
    logic                found;
    logic [23:0]         opnd_d, opnd_q;
    logic [LOG_LATENCY:0] tag_v_d, tag_v_q;
    logic [IW-1:0]       tag_idx_d [LOG_LATENCY+1];
    logic [IW-1:0]       tag_idx_q [LOG_LATENCY+1];
    logic [11:0]         log_out;

    function automatic logic [IW-1:0] wrap(input int v);
        return IW'(v >= N_REQ ? v - N_REQ : v);
    endfunction

    assign elig = req & ~busy_q;

`ifdef NATURAL_LOG_ARBITER_CACHE_EN
    logic [N_REQ*24-1:0] cached_d, cached_q;
    logic [N_REQ-1:0]    cache_valid_d, cache_valid_q;
    always_comb begin
        hit = '0;
        for (int i = 0; i < N_REQ; i++)
            hit[i] = elig[i] & cache_valid_q[i] & (in_8_shifted[i*24 +: 24] == cached_q[i*24 +: 24]);
    end
    // The issued operand is latched at grant but only trusted once its result has landed.
    always_comb begin
        cached_d = cached_q;
        for (int i = 0; i < N_REQ; i++)
            cached_d[i*24 +: 24] = sel_oh[i] ? in_8_shifted[i*24 +: 24] : cached_q[i*24 +: 24];
        cache_valid_d = (cache_valid_q & ~sel_oh) | fin_oh;
    end
    always_ff @(posedge clk) begin
        cached_q      <= cached_d;
        cache_valid_q <= reset ? '0 : cache_valid_d;
    end
`else
    assign hit = '0;
`endif

    always_comb begin
        cand  = elig & ~hit;
        found = 1'b0;
        sel   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!found && cand[wrap(int'(ptr_q) + k)]) begin
                found = 1'b1;
                sel   = wrap(int'(ptr_q) + k);
            end
        end
        sel_oh  = found ? N_REQ'(1) << sel : '0;
        fin_oh  = tag_v_q[LOG_LATENCY] ? N_REQ'(1) << tag_idx_q[LOG_LATENCY] : '0;
        ptr_d   = found ? wrap(int'(sel) + 1) : ptr_q;
        opnd_d  = found ? in_8_shifted[int'(sel)*24 +: 24] : opnd_q;
        grant_d = sel_oh | hit;
        done_d  = fin_oh | hit;
        busy_d  = (busy_q & ~fin_oh) | sel_oh;
        tag_v_d = {tag_v_q[LOG_LATENCY-1:0], found};
        tag_idx_d[0] = sel;
        for (int s = 1; s <= LOG_LATENCY; s++)
            tag_idx_d[s] = tag_idx_q[s-1];
        out_d = out_q;
        for (int i = 0; i < N_REQ; i++)
            out_d[i*12 +: 12] = fin_oh[i] ? log_out : out_q[i*12 +: 12];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q <= '0;
            busy_q  <= '0;
            done_q  <= '0;
            out_q   <= '0;
            ptr_q   <= '0;
            tag_v_q <= '0;
        end else begin
            grant_q <= grant_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            out_q   <= out_d;
            ptr_q   <= ptr_d;
            tag_v_q <= tag_v_d;
        end
    end

    always_ff @(posedge clk) begin
        opnd_q    <= opnd_d;
        tag_idx_q <= tag_idx_d;
    end

    natural_log u_log (
        .clk          (clk),
        .in_8_shifted (opnd_q),
        .out_8_shifted(log_out)
    );

    assign grant         = grant_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign out_8_shifted = out_q;
endmodule

// natural_log: ln of an unsigned 16.8 operand as unsigned 4.8, three register stages.
// Operands below 1.0 (including 0) saturate to 0; log2 fraction uses f + 0.34375*f*(1-f).
module natural_log (
    input  logic        clk,
    input  logic [23:0] in_8_shifted,
    output logic [11:0] out_8_shifted
);
    localparam logic [15:0] LN2 = 16'd45426;
    logic        small_d, small_q, small2_d, small2_q;
    logic [3:0]  exp_d, exp_q;
    logic [15:0] frac_d, frac_q;
    logic [19:0] log2_d, log2_q;
    logic [11:0] ln_d, ln_q;
    logic [4:0]  msb;
    logic [23:0] norm;
    logic [32:0] parab;
    logic [23:0] corr;
    logic [35:0] prod;

    always_comb begin
        msb = 5'd8;
        for (int i = 9; i < 24; i++)
            if (in_8_shifted[i]) msb = 5'(i);
        norm    = in_8_shifted << (5'd23 - msb);
        small_d = in_8_shifted[23:8] == 16'd0;
        exp_d   = 4'(msb - 5'd8);
        frac_d  = 16'(norm >> 7);
    end

    always_comb begin
        parab    = {17'd0, frac_q} * (33'h10000 - {17'd0, frac_q});
        corr     = {8'd0, 16'(parab >> 16)} * 24'd88;
        log2_d   = {exp_q, 16'({8'd0, frac_q} + (corr >> 8))};
        small2_d = small_q;
    end

    always_comb begin
        prod = {16'd0, log2_q} * {20'd0, LN2};
        ln_d = small2_q ? 12'd0 : 12'(prod >> 24);
    end

    always_ff @(posedge clk) begin
        small_q  <= small_d;
        exp_q    <= exp_d;
        frac_q   <= frac_d;
        small2_q <= small2_d;
        log2_q   <= log2_d;
        ln_q     <= ln_d;
    end

    assign out_8_shifted = ln_q;
endmodule
